// File: rtl/mem_bus_responder.sv
// mem_bus_responder: slave end of the main CPU/memory bus.
// Accepts a multiplexed address phase ({page, base} on bus_din with AddrValid),
// answers only to its own PAGE, then runs a fixed 4-beat burst against the
// memory array, wrapping the word address modulo 2^ADDRWIDTH.
//
// Ports:
//   clk        system clock, rising edge
//   resetH     synchronous active-high reset
//   AddrValid  one-cycle address-phase marker from the master
//   rw         1 = read, 0 = write (sampled with AddrValid)
//   bus_din    address phase {page, base}; write data beats afterwards
//   bus_dout   read data beat (valid while bus_oe)
//   bus_oe     responder drives bus_dout this cycle
//   busy       burst in progress
//   mem_addr   memory word address
//   mem_wdata  memory write data
//   mem_wr_en  memory write strobe (written at rising edge)
//   mem_rd_en  memory read strobe
//   mem_rdata  memory read data, combinational from mem_addr
module mem_bus_responder #(
    parameter int unsigned BUSWIDTH        = 16,
    parameter int unsigned DATAPAYLOADSIZE = 4,
    parameter int unsigned ADDRWIDTH       = 12,
    parameter int unsigned PAGEWIDTH       = 4,
    parameter logic [PAGEWIDTH-1:0] PAGE   = 4'h2
) (
    input  logic                 clk,
    input  logic                 resetH,
    input  logic                 AddrValid,
    input  logic                 rw,
    input  logic [BUSWIDTH-1:0]  bus_din,
    output logic [BUSWIDTH-1:0]  bus_dout,
    output logic                 bus_oe,
    output logic                 busy,
    output logic [ADDRWIDTH-1:0] mem_addr,
    output logic [BUSWIDTH-1:0]  mem_wdata,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    input  logic [BUSWIDTH-1:0]  mem_rdata
);

    localparam int unsigned CNTW = (DATAPAYLOADSIZE > 1) ? $clog2(DATAPAYLOADSIZE) : 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(DATAPAYLOADSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNTW-1:0]      cnt, cnt_nxt;
    logic [ADDRWIDTH-1:0] base, base_nxt;
    logic                 rw_q, rw_nxt;
    logic [ADDRWIDTH-1:0] beat_addr;
    logic                 page_hit;

    // State register and burst context.
    always_ff @(posedge clk) begin
        if (resetH) begin
            state <= IDLE;
            cnt   <= '0;
            base  <= '0;
            rw_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            base  <= base_nxt;
            rw_q  <= rw_nxt;
        end
    end

    // Natural ADDRWIDTH overflow gives the required wrap (FFE, FFF, 000, 001).
    assign beat_addr = base + ADDRWIDTH'(cnt);
    assign page_hit  = (bus_din[BUSWIDTH-1 -: PAGEWIDTH] == PAGE);

    // Next-state and burst outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        base_nxt  = base;
        rw_nxt    = rw_q;
        bus_dout  = '0;
        bus_oe    = 1'b0;
        busy      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;

        case (state)
            IDLE: begin
                if (AddrValid && page_hit) begin
                    base_nxt  = bus_din[ADDRWIDTH-1:0];
                    cnt_nxt   = '0;
                    rw_nxt    = rw;
                    state_nxt = rw ? RD : WR;
                end
            end
            RD: begin
                busy      = 1'b1;
                bus_oe    = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = beat_addr;
                bus_dout  = mem_rdata;
            end
            WR: begin
                busy      = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = beat_addr;
                mem_wdata = bus_din;
            end
            default: state_nxt = IDLE;
        endcase

        // Beat counting shared by both burst directions; AddrValid is ignored here.
        if (state == RD || state == WR) begin
            if (cnt == LAST_BEAT) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                cnt_nxt = cnt + CNTW'(1);
            end
        end

        // Quiet bus and no memory write in the cycle reset is sampled.
        if (resetH) begin
            bus_dout  = '0;
            bus_oe    = 1'b0;
            busy      = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wr_en = 1'b0;
            mem_rd_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: stimulus pushes expected read beats
// and memory writes into queues; a negedge monitor pops and compares them.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        resetH;
    logic        AddrValid;
    logic        rw;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic        bus_oe;
    logic        busy;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;

    logic        mem_clear;
    logic [15:0] mem [4096];

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rd_q[$];
    logic [27:0] wr_q[$];

    mem_bus_responder dut (
        .clk       (clk),
        .resetH    (resetH),
        .AddrValid (AddrValid),
        .rw        (rw),
        .bus_din   (bus_din),
        .bus_dout  (bus_dout),
        .bus_oe    (bus_oe),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory array model: combinational read, write at rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus drive or memory write must match the next expectation.
    always @(negedge clk) begin
        if (bus_oe === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read: bus_dout %h with nothing expected (t=%0t)", bus_dout, $time);
            end else begin
                check("rd_data", 32'(bus_dout), 32'(rd_q.pop_front()));
            end
        end
        if (mem_wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %h data %h with nothing expected (t=%0t)", mem_addr, mem_wdata, $time);
            end else begin
                check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(wr_q.pop_front()));
            end
        end
    end

    // Address phase plus 4 beats. data holds beat0 in the top 16 bits: write
    // data to drive, or expected read data. av_beat marks a beat carrying a
    // stray AddrValid (its data word is still driven as write data).
    task automatic burst(input logic rd, input logic [3:0] pg, input logic [11:0] base,
                         input logic [63:0] data, input int av_beat);
        logic        act;
        logic [15:0] w;
        act = (pg == 4'h2);
        @(posedge clk); #1;
        AddrValid = 1'b1;
        rw        = rd;
        bus_din   = {pg, base};
        @(negedge clk);
        check("addr_cycle_busy", 32'(busy), 32'(0));
        check("addr_cycle_oe", 32'(bus_oe), 32'(0));
        for (int k = 0; k < 4; k++) begin
            w = data[(3-k)*16 +: 16];
            if (act) begin
                if (rd) rd_q.push_back(w);
                else    wr_q.push_back({12'(base + 12'(k)), w});
            end
            @(posedge clk); #1;
            AddrValid = (k == av_beat);
            rw        = (k == av_beat) ? 1'b1 : rd;
            bus_din   = rd ? 16'h0000 : w;
            @(negedge clk);
            check("beat_busy", 32'(busy), 32'(act));
            check("beat_oe", 32'(bus_oe), 32'(act && rd));
            check("beat_wr_en", 32'(mem_wr_en), 32'(act && !rd));
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        AddrValid = 1'b0;
        rw        = 1'b0;
        bus_din   = 16'h0000;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_oe", 32'(bus_oe), 32'(0));
        check("idle_wr_en", 32'(mem_wr_en), 32'(0));
        check("idle_rd_en", 32'(mem_rd_en), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetH    = 1'b1;
        mem_clear = 1'b1;
        AddrValid = 1'b1;
        rw        = 1'b1;
        bus_din   = {4'h2, 12'h123};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_oe", 32'(bus_oe), 32'(0));
        check("reset_dout", 32'(bus_dout), 32'(0));
        check("reset_addr", 32'(mem_addr), 32'(0));
        check("reset_rd_en", 32'(mem_rd_en), 32'(0));
        @(posedge clk); #1;
        resetH    = 1'b0;
        mem_clear = 1'b0;
        AddrValid = 1'b0;
        rw        = 1'b0;
        bus_din   = 16'h0000;
        idle_cycle();

        // Write with address wrap FFE, FFF, 000, 001, then read it back.
        burst(1'b0, 4'h2, 12'hFFE, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, -1);
        idle_cycle();
        burst(1'b1, 4'h2, 12'hFFE, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, -1);
        idle_cycle();

        // Other page is ignored; F00 still holds its preload.
        burst(1'b0, 4'h0, 12'hF00, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, -1);
        idle_cycle();
        burst(1'b1, 4'h2, 12'hF00, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, -1);
        idle_cycle();

        // Stray read request {2,100} on beat 2 of a write is just data.
        burst(1'b0, 4'h2, 12'h200, {16'h5555, 16'h6666, 16'h2100, 16'h7777}, 2);
        idle_cycle();
        idle_cycle();
        burst(1'b1, 4'h2, 12'h200, {16'h5555, 16'h6666, 16'h2100, 16'h7777}, -1);
        idle_cycle();

        // Reset during the second beat of a write to 010.
        @(posedge clk); #1;
        AddrValid = 1'b1;
        rw        = 1'b0;
        bus_din   = {4'h2, 12'h010};
        wr_q.push_back({12'h010, 16'hAAAA});
        @(posedge clk); #1;
        AddrValid = 1'b0;
        bus_din   = 16'hAAAA;
        @(negedge clk);
        check("rst_beat0_wr_en", 32'(mem_wr_en), 32'(1));
        @(posedge clk); #1;
        resetH  = 1'b1;
        bus_din = 16'hBBBB;
        @(negedge clk);
        check("rst_cycle_wr_en", 32'(mem_wr_en), 32'(0));
        check("rst_cycle_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        resetH  = 1'b0;
        bus_din = 16'hCCCC;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_wr_en", 32'(mem_wr_en), 32'(0));
        check("post_rst_addr", 32'(mem_addr), 32'(0));
        check("post_rst_wdata", 32'(mem_wdata), 32'(0));
        idle_cycle();
        burst(1'b1, 4'h2, 12'h010, {16'hAAAA, 16'h0000, 16'h0000, 16'h0000}, -1);
        idle_cycle();

        // Back-to-back reads: second address phase right after the last beat.
        burst(1'b0, 4'h2, 12'h020, {16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04}, -1);
        idle_cycle();
        burst(1'b1, 4'h2, 12'h020, {16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04}, -1);
        burst(1'b1, 4'h2, 12'h022, {16'h0A03, 16'h0A04, 16'h0000, 16'h0000}, -1);
        idle_cycle();
        idle_cycle();

        check("rd_q_drained", 32'(rd_q.size()), 32'(0));
        check("wr_q_drained", 32'(wr_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side bus responder for the CPU/memory system: the slave end of the main bus that the processor-side master drives with read and write requests.
- Decodes a multiplexed address phase and checks the 4-bit page against its assigned page.
- Performs a 4-beat burst of BUSWIDTH words against a 4K-word memory array, with 12-bit address rollover.
- Sits between the main bus and the memory array instance.

Parameters:
- BUSWIDTH, 16, width of bus data/address word.
- DATAPAYLOADSIZE, 4, beats per burst.
- ADDRWIDTH, 12, memory word address width; burst addresses wrap modulo 2^ADDRWIDTH.
- PAGEWIDTH, 4, page field width; BUSWIDTH = PAGEWIDTH + ADDRWIDTH.
- PAGE, 4'h2, page this responder answers to.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- resetH  in  1  synchronous active-high reset.
- AddrValid  in  1  master asserts for exactly one cycle to mark the address phase.
- rw  in  1  sampled with AddrValid: 1 = read, 0 = write.
- bus_din  in  BUSWIDTH  address phase {page, baseaddr}; write-data beats afterwards.
- bus_dout  out  BUSWIDTH  read data beat.
- bus_oe  out  1  responder drives bus_dout this cycle.
- busy  out  1  burst in progress.
- mem_addr  out  ADDRWIDTH  memory word address.
- mem_wdata  out  BUSWIDTH  memory write data.
- mem_wr_en  out  1  memory write strobe; the memory writes at the rising edge while high.
- mem_rd_en  out  1  memory read strobe.
- mem_rdata  in  BUSWIDTH  memory read data; combinational from mem_addr.

Behaviour:
- Reset, synchronous: when resetH is sampled high, next state is IDLE, beat counter 0, latched base 0, latched rw 0.
- Outputs while in IDLE or while resetH is high: bus_oe=0, bus_dout=0, busy=0, mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0.
- mem_wr_en is additionally gated by !resetH, so no memory write occurs in the cycle reset is sampled.
- States: IDLE, RD, WR.
- IDLE: at a rising edge with AddrValid=1 and bus_din[BUSWIDTH-1 -: PAGEWIDTH]==PAGE:
  - latch base=bus_din[ADDRWIDTH-1:0];
  - clear cnt to 0;
  - go to RD if rw=1, else WR.
- IDLE, page mismatch or AddrValid=0: stay in IDLE. No bus drive and no memory access for the whole burst.
- Data beats occupy the DATAPAYLOADSIZE cycles that immediately follow the address cycle (beat k = cycle A+1+k).
- Beat address: mem_addr = (base + cnt) mod 2^ADDRWIDTH. Example: base FFE gives FFE, FFF, 000, 001.
- RD, each beat: mem_rd_en=1; bus_oe=1; bus_dout=mem_rdata, combinational. The master samples the beat at the rising edge ending that cycle.
- WR, each beat: mem_wr_en=1; mem_wdata=bus_din; the word is written at the rising edge ending that beat.
- busy=1 in RD and WR.
- cnt increments each beat. When cnt==DATAPAYLOADSIZE-1, the next state is IDLE and cnt returns to 0.
- AddrValid during RD/WR is ignored. There is no pipelining or queuing, and bus_din is treated as data.
- Back-to-back bursts: an AddrValid in the first cycle back in IDLE (A+DATAPAYLOADSIZE+1) is accepted normally. Minimum request spacing is 5 cycles.
- Reset mid-burst: remaining beats are abandoned. Beats completed before the reset edge stay written; no write occurs in the reset cycle.
- Latency: read data appears 1 cycle after the address phase. Burst length is fixed at 4 beats.

Test Plan:
- Write page 2, base FFE, data 1111, 2222, 3333, 4444: mem_wr_en high for 4 cycles at addresses FFE, FFF, 000, 001; memory then holds those values; busy high for 4 cycles.
- Read page 2, base FFE after the write: bus_oe high for beats 1-4 with bus_dout 1111, 2222, 3333, 4444; returns to IDLE with bus_oe=0 on cycle 5.
- Write page 0, base F00, data FFFF ×4: no mem_wr_en, bus_oe, or busy ever asserted. A following read of page 2, base F00 returns the preloaded value (0000) on all 4 beats.
- AddrValid pulsed (page 2, read, base 100) during beat 2 of a write: write completes at the original 4 addresses, no read burst starts, and the bus_din value on that beat is written as data.
- resetH asserted for 1 cycle during beat 1 (second beat) of a write to base 010: only address 010 is written, 011-013 are unchanged, and all outputs are 0 from the next cycle on.
- Back-to-back: a read at page 2, base 020, followed by AddrValid exactly one cycle after its last beat: the second burst is accepted, with bus_oe gapped low for only the single address cycle.
